// File: rtl/cpuc_package.sv
// Shared CPUC constants and the types used by the RAM copy/fill engine.
package cpuc_package;

    localparam int unsigned ADDR_WIDTH = 5;
    localparam int unsigned DATA_WIDTH = 8;
    localparam int unsigned MEM_SIZE   = 32;
    localparam int unsigned LEN_WIDTH  = ADDR_WIDTH + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } t_dma_state;

    typedef enum logic {
        DMA_COPY = 1'b0,
        DMA_FILL = 1'b1
    } t_dma_op;

endpackage

// File: rtl/cpuc_ram_dma.sv
// Copy (memmove) / fill engine driving one read port and one write port of the CPUC RAM.
// Accepts one command per handshake and moves one word per clock.
module cpuc_ram_dma
    import cpuc_package::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_op,
    input  logic [ADDR_WIDTH-1:0] cmd_src,
    input  logic [ADDR_WIDTH-1:0] cmd_dst,
    input  logic [LEN_WIDTH-1:0]  cmd_len,
    input  logic [DATA_WIDTH-1:0] cmd_fill,
    output logic [ADDR_WIDTH-1:0] rd_address,
    input  logic [DATA_WIDTH-1:0] rd_q,
    output logic [ADDR_WIDTH-1:0] wr_address,
    output logic                  wr_wren,
    output logic [DATA_WIDTH-1:0] wr_data,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);

    localparam int unsigned EXT_W = LEN_WIDTH + 1;

    t_dma_state            r_state;
    t_dma_op               r_op;
    logic [LEN_WIDTH-1:0]  r_len;
    logic [LEN_WIDTH-1:0]  r_cnt;
    logic [DATA_WIDTH-1:0] r_fill;
    logic [ADDR_WIDTH-1:0] r_rd_addr;
    logic [ADDR_WIDTH-1:0] r_wr_addr;
    logic                  r_desc;
    logic                  r_wren;
    logic                  r_ready;
    logic                  r_busy;
    logic                  r_done;
    logic                  r_err;

    logic [EXT_W-1:0]      w_src_ext;
    logic [EXT_W-1:0]      w_dst_ext;
    logic [EXT_W-1:0]      w_src_end;
    logic [EXT_W-1:0]      w_dst_end;
    logic                  w_is_copy;
    logic                  w_reject;
    logic                  w_desc;
    logic                  w_last;
    logic [ADDR_WIDTH-1:0] w_last_off;

    // Range and direction decisions, computed wide enough that src/dst + len never wraps.
    assign w_src_ext  = EXT_W'(cmd_src);
    assign w_dst_ext  = EXT_W'(cmd_dst);
    assign w_src_end  = w_src_ext + EXT_W'(cmd_len);
    assign w_dst_end  = w_dst_ext + EXT_W'(cmd_len);
    assign w_is_copy  = (t_dma_op'(cmd_op) == DMA_COPY);
    assign w_reject   = (w_dst_end > EXT_W'(MEM_SIZE)) ||
                        (w_is_copy && (w_src_end > EXT_W'(MEM_SIZE)));
    assign w_desc     = w_is_copy && (w_dst_ext > w_src_ext) && (w_dst_ext < w_src_end);
    assign w_last_off = ADDR_WIDTH'(cmd_len - LEN_WIDTH'(1));
    assign w_last     = (r_cnt == (r_len - LEN_WIDTH'(1)));

    assign cmd_ready  = r_ready;
    assign busy       = r_busy;
    assign done       = r_done;
    assign err        = r_err;
    assign rd_address = r_rd_addr;
    assign wr_address = r_wr_addr;
    assign wr_wren    = r_wren;
    // Read data is combinational, so a COPY write forwards the word read this same cycle.
    assign wr_data    = r_wren ? ((r_op == DMA_COPY) ? rd_q : r_fill) : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_op      <= DMA_COPY;
            r_len     <= '0;
            r_cnt     <= '0;
            r_fill    <= '0;
            r_rd_addr <= '0;
            r_wr_addr <= '0;
            r_desc    <= 1'b0;
            r_wren    <= 1'b0;
            r_ready   <= 1'b1;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (cmd_valid) begin
                        r_op    <= t_dma_op'(cmd_op);
                        r_len   <= cmd_len;
                        r_fill  <= cmd_fill;
                        r_desc  <= w_desc;
                        r_cnt   <= '0;
                        r_ready <= 1'b0;
                        r_busy  <= 1'b1;
                        if ((cmd_len != '0) && !w_reject) begin
                            r_state <= RUN;
                            r_wren  <= 1'b1;
                            // Descending copies start at the top word of each range.
                            r_rd_addr <= w_desc ? ADDR_WIDTH'(cmd_src + w_last_off) : cmd_src;
                            r_wr_addr <= w_desc ? ADDR_WIDTH'(cmd_dst + w_last_off) : cmd_dst;
                        end else begin
                            r_state <= DONE;
                            r_done  <= 1'b1;
                            r_err   <= w_reject;
                        end
                    end
                end
                RUN: begin
                    r_cnt <= r_cnt + LEN_WIDTH'(1);
                    if (w_last) begin
                        r_state   <= DONE;
                        r_wren    <= 1'b0;
                        r_rd_addr <= '0;
                        r_wr_addr <= '0;
                        r_done    <= 1'b1;
                    end else if (r_desc) begin
                        r_rd_addr <= r_rd_addr - ADDR_WIDTH'(1);
                        r_wr_addr <= r_wr_addr - ADDR_WIDTH'(1);
                    end else begin
                        r_rd_addr <= r_rd_addr + ADDR_WIDTH'(1);
                        r_wr_addr <= r_wr_addr + ADDR_WIDTH'(1);
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                    r_ready <= 1'b1;
                end
                default: begin
                    r_state <= IDLE;
                    r_wren  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: doc/cpuc_ram_dma.md
# cpuc_ram_dma

Copy/fill engine that sits directly upstream of the CPUC quad-port RAM and owns two of its four ports: one used read-only, one used write-only. It accepts a single command per handshake, then moves one data word per clock. Copy has memmove semantics, so overlapping regions are handled correctly. Fill writes a constant to a range. Completion or rejection is reported with a one-cycle pulse.

## Interface
- Parameters: none local. Uses `ADDR_WIDTH`, `DATA_WIDTH` and `MEM_SIZE` from `cpuc_package`, plus `LEN_WIDTH` (= `ADDR_WIDTH+1`, package constant).
- Clocking and reset (already decided): one clock, `clk`; reset `rst` is asynchronous and active-high.
- `clk`  in  1  — sole clock; all state updates on its rising edge.
- `rst`  in  1  — asynchronous, active-high reset.
- `cmd_valid`  in  1  — command present.
- `cmd_ready`  out  1  — engine can accept a command; high only in IDLE.
- `cmd_op`  in  1  — 0 = COPY, 1 = FILL.
- `cmd_src`  in  ADDR_WIDTH  — source base address; ignored for FILL.
- `cmd_dst`  in  ADDR_WIDTH  — destination base address.
- `cmd_len`  in  LEN_WIDTH  — word count, 0..MEM_SIZE.
- `cmd_fill`  in  DATA_WIDTH  — FILL value.
- `rd_address`  out  ADDR_WIDTH  — drives RAM port address (read port); `wren` for this port is tied to 0 outside the block.
- `rd_q`  in  DATA_WIDTH  — RAM read data for `rd_address`, combinational.
- `wr_address`  out  ADDR_WIDTH  — drives RAM write-port address.
- `wr_wren`  out  1  — RAM write enable.
- `wr_data`  out  DATA_WIDTH  — RAM write data.
- `busy`  out  1  — state is not IDLE.
- `done`  out  1  — one-cycle pulse when a command completes or is rejected.
- `err`  out  1  — one-cycle pulse, coincident with `done`, when a command is rejected.

## Operation
- States:
  - IDLE: on `cmd_valid` && `cmd_ready` → RUN when `len` > 0 and the range check passes; otherwise → DONE.
  - RUN: → DONE after the last word.
  - DONE: → IDLE after one cycle.
- Accept: the command fields are latched into registers in the accept cycle. Inputs are not sampled again until the next IDLE.
- Range check, done in LEN_WIDTH+1 bits with no wrap:
  - FILL: reject if `dst + len > MEM_SIZE`.
  - COPY: reject if `dst + len > MEM_SIZE` or `src + len > MEM_SIZE`.
  - A rejected command performs no writes and gives `err`=1 together with `done`.
- Direction: descending when COPY && `dst > src` && `dst < src + len`; ascending otherwise.
- Index counter `cnt` runs 0..len-1. Offset `off` = descending ? `len-1-cnt` : `cnt`.
- In RUN, every cycle:
  - `rd_address` = `src + off`.
  - `wr_address` = `dst + off`.
  - `wr_wren` = 1.
  - `wr_data` = COPY ? `rd_q` : `fill`.
  - `cnt` increments.
- `dst == src` COPY: executes normally (rewrites the same data).
- Outside RUN: `wr_wren`=0, and `rd_address`/`wr_address`/`wr_data` = 0.
- A new `cmd_valid` during RUN or DONE is held off by `cmd_ready`=0. The command source must keep its fields stable until accepted.

## Timing
- Reset values while `rst` is high: state IDLE, `cnt`=0, all outputs 0 except `cmd_ready`=1.
- Command accepted at edge T: writes occur in cycles T+1..T+len, committed at the end of each of those cycles.
- `done` (and `err` if rejected) is high in cycle T+len+1. For `len`=0 or a rejected command, it is high in cycle T+1.
- `cmd_ready` returns to 1 in cycle T+len+2. Sustained throughput is therefore len+2 cycles per command.
- `busy` is high from T+1 through the DONE cycle.
- RAM reads are combinational, so each COPY write uses data read in the same cycle. Descending order guarantees no source word is overwritten before it is read.
- Reset asserted mid-RUN:
  - `wr_wren` drops immediately (asynchronously).
  - Words already written stay written.
  - No `done` pulse is issued.
- Full-memory case (`len` = MEM_SIZE, `dst` = 0): the counter must not overflow. Use an LEN_WIDTH-bit `cnt` with the compare `cnt == len-1` detecting the last word.

## Structure
- In `cpuc_package`:
  - `t_dma_state` enum {IDLE, RUN, DONE}.
  - `t_dma_op` enum {DMA_COPY, DMA_FILL}.
  - `LEN_WIDTH`.
- Flat module, no sub-module. Address generation is a few adders and a mux.
- Top-level integration: `rd_*` connects to RAM interface C, `wr_*` to interface D. Interfaces A/B remain with the core.

## Test plan
- FILL `dst`=4, `len`=3, `fill`=0xAB → `wr_wren` high for exactly 3 cycles at addresses 4, 5, 6. Mem[4..6]=0xAB, mem[7] unchanged, `done` at T+4, `err`=0.
- COPY non-overlap, mem[0..3]={1,2,3,4}, `src`=0, `dst`=8, `len`=4 → mem[8..11]={1,2,3,4}, ascending addresses 8→11.
- COPY overlap forward, mem[0..3]={1,2,3,4}, `src`=0, `dst`=2, `len`=4 → write order 5, 4, 3, 2. Final mem[2..5]={1,2,3,4}.
- COPY overlap backward, `src`=2, `dst`=0, `len`=4 → ascending order. Mem[0..3] = old mem[2..5].
- `len`=0, and separately `dst`=MEM_SIZE-2 with `len`=3 → no `wr_wren` in either case. `done` at T+1; `err`=0 then `err`=1 respectively. `cmd_ready` back at T+2.
- Reset pulse in the 2nd RUN cycle of a `len`=8 FILL → `wr_wren` low immediately, only 1–2 words written, no `done`. `cmd_ready`=1 after release, and the next command executes normally.
